// File: rtl/taxi_axis_if.sv
// AXI4-Stream interface: payload plus optional sidebands, each gated by an enable.
interface taxi_axis_if #(
  parameter int DATA_W  = 8,
  parameter bit KEEP_EN = (DATA_W > 8),
  parameter int KEEP_W  = (DATA_W + 7) / 8,
  parameter bit STRB_EN = 1'b0,
  parameter bit LAST_EN = 1'b1,
  parameter bit ID_EN   = 1'b0,
  parameter int ID_W    = 8,
  parameter bit DEST_EN = 1'b0,
  parameter int DEST_W  = 8,
  parameter bit USER_EN = 1'b0,
  parameter int USER_W  = 1
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport src (output tdata, tkeep, tstrb, tid, tdest, tuser, tlast, tvalid, input tready);
  modport snk (input tdata, tkeep, tstrb, tid, tdest, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/taxi_axis_frame_trunc.sv
// Frame length limiter: forwards frames up to max_len beats, cuts longer ones
// (forced tlast + error bit in tuser) and swallows their tail. Registered
// output with a two-entry skid so the input ready is fully registered.
module taxi_axis_frame_trunc #(
  parameter int LEN_W          = 16,
  parameter int CNT_W          = 32,
  parameter int TRUNC_USER_BIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  taxi_axis_if.snk         s_axis,
  taxi_axis_if.src         m_axis,
  input  logic [LEN_W-1:0] max_len,
  output logic             stat_frame,
  output logic             stat_trunc,
  output logic [CNT_W-1:0] trunc_count,
  output logic             busy
);
  localparam int DATA_W  = s_axis.DATA_W;
  localparam bit KEEP_EN = s_axis.KEEP_EN && m_axis.KEEP_EN;
  localparam int KEEP_W  = s_axis.KEEP_W;
  localparam bit STRB_EN = s_axis.STRB_EN && m_axis.STRB_EN;
  localparam bit LAST_EN = s_axis.LAST_EN;
  localparam bit ID_EN   = s_axis.ID_EN && m_axis.ID_EN;
  localparam int ID_W    = s_axis.ID_W;
  localparam bit DEST_EN = s_axis.DEST_EN && m_axis.DEST_EN;
  localparam int DEST_W  = s_axis.DEST_W;
  localparam bit USER_EN = m_axis.USER_EN;
  localparam int USER_W  = s_axis.USER_W;

  if (m_axis.DATA_W != DATA_W || m_axis.KEEP_W != KEEP_W) begin : g_param_chk
    $fatal(0, "taxi_axis_frame_trunc: s_axis/m_axis DATA_W or KEEP_W mismatch");
  end

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [KEEP_W-1:0] strb;
    logic [ID_W-1:0]   id;
    logic [DEST_W-1:0] dest;
    logic [USER_W-1:0] user;
    logic              last;
  } beat_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] beat_cnt_reg, cnt_next, len_reg, len_next, lim, n;
  logic             s_tready_reg, m_tvalid_reg, temp_tvalid_reg;
  logic             m_tvalid_next, temp_tvalid_next, s_tready_early;
  logic             st_in_out, st_in_temp, st_temp_out;
  logic             accept, in_last, trunc, frame_done;
  beat_t            in_beat, m_beat, temp_beat;

  // The limit is live only on the first beat; afterwards the latched copy rules.
  assign lim     = (state_reg == IDLE) ? max_len : len_reg;
  assign n       = (&beat_cnt_reg) ? beat_cnt_reg : beat_cnt_reg + 1'b1;
  assign in_last = LAST_EN ? s_axis.tlast : 1'b1;
  assign accept  = s_axis.tvalid && s_tready_reg;

  // Frame tracking: next state, beat count and truncation decision per accepted beat.
  always_comb begin
    state_next = state_reg;
    cnt_next   = beat_cnt_reg;
    len_next   = len_reg;
    trunc      = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE, PASS: begin
        if (accept) begin
          if (state_reg == IDLE) len_next = max_len;
          if (in_last) begin
            // A frame ending exactly at the limit is not a truncation.
            cnt_next   = '0;
            frame_done = 1'b1;
            state_next = IDLE;
          end else if (lim != '0 && n == lim) begin
            cnt_next   = '0;
            trunc      = 1'b1;
            state_next = DROP;
          end else begin
            cnt_next   = n;
            state_next = PASS;
          end
        end
      end
      DROP: begin
        if (accept && in_last) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Input beat as it will be stored: disabled sidebands forced, cut beat marked.
  always_comb begin
    in_beat.data = s_axis.tdata;
    in_beat.keep = KEEP_EN ? s_axis.tkeep : '1;
    in_beat.strb = STRB_EN ? s_axis.tstrb : in_beat.keep;
    in_beat.id   = ID_EN ? s_axis.tid : '0;
    in_beat.dest = DEST_EN ? s_axis.tdest : '0;
    in_beat.user = USER_EN ? s_axis.tuser : '0;
    in_beat.last = in_last | trunc;
    if (USER_EN && trunc) in_beat.user[TRUNC_USER_BIT] = 1'b1;
  end

  // Skid steering: input goes to output reg if it frees up, else to temp; dropped beats go nowhere.
  always_comb begin
    m_tvalid_next    = m_tvalid_reg;
    temp_tvalid_next = temp_tvalid_reg;
    st_in_out        = 1'b0;
    st_in_temp       = 1'b0;
    st_temp_out      = 1'b0;
    if (s_tready_reg && state_reg != DROP) begin
      if (m_axis.tready || !m_tvalid_reg) begin
        m_tvalid_next = s_axis.tvalid;
        st_in_out     = 1'b1;
      end else begin
        temp_tvalid_next = s_axis.tvalid;
        st_in_temp       = 1'b1;
      end
    end else if (m_axis.tready) begin
      m_tvalid_next    = temp_tvalid_reg;
      temp_tvalid_next = 1'b0;
      st_temp_out      = 1'b1;
    end
  end

  assign s_tready_early = m_axis.tready || (!temp_tvalid_reg && (!m_tvalid_reg || !s_axis.tvalid));

  // Control and status state; DROP keeps the input open regardless of the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      beat_cnt_reg    <= '0;
      len_reg         <= '0;
      s_tready_reg    <= 1'b0;
      m_tvalid_reg    <= 1'b0;
      temp_tvalid_reg <= 1'b0;
      stat_frame      <= 1'b0;
      stat_trunc      <= 1'b0;
      trunc_count     <= '0;
    end else begin
      state_reg       <= state_next;
      beat_cnt_reg    <= cnt_next;
      len_reg         <= len_next;
      s_tready_reg    <= (state_next == DROP) || s_tready_early;
      m_tvalid_reg    <= m_tvalid_next;
      temp_tvalid_reg <= temp_tvalid_next;
      stat_frame      <= frame_done;
      stat_trunc      <= trunc;
      if (trunc && !(&trunc_count)) trunc_count <= trunc_count + 1'b1;
    end
  end

  // Payload registers; contents only matter while the matching valid is set.
  always_ff @(posedge clk) begin
    if (st_in_out) m_beat <= in_beat;
    else if (st_temp_out) m_beat <= temp_beat;
    if (st_in_temp) temp_beat <= in_beat;
  end

  assign s_axis.tready = s_tready_reg;
  assign m_axis.tvalid = m_tvalid_reg;
  assign m_axis.tdata  = m_beat.data;
  assign m_axis.tkeep  = m_beat.keep;
  assign m_axis.tstrb  = m_beat.strb;
  assign m_axis.tid    = m_beat.id;
  assign m_axis.tdest  = m_beat.dest;
  assign m_axis.tuser  = m_beat.user;
  assign m_axis.tlast  = m_beat.last;
  assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_taxi_axis_frame_trunc.sv
// Bench for taxi_axis_frame_trunc: frame-level reference model, table of
// frame vectors, random backpressure run, and hand sequences for latency,
// mid-frame limit change and asynchronous reset.
module tb_taxi_axis_frame_trunc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(16), .KEEP_EN(1), .KEEP_W(2), .ID_EN(1), .ID_W(4),
                 .USER_EN(1), .USER_W(3)) s_if (), m_if ();

  logic [15:0] max_len;
  logic        stat_frame, stat_trunc, busy;
  logic [31:0] trunc_count;

  taxi_axis_frame_trunc #(.LEN_W(16), .CNT_W(32), .TRUNC_USER_BIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if), .max_len(max_len),
    .stat_frame(stat_frame), .stat_trunc(stat_trunc), .trunc_count(trunc_count), .busy(busy)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic [3:0]  id;
    logic [2:0]  user;
    logic        last;
  } beat_t;

  typedef struct {
    int len;
    int lim;
    int rdy;
    int exp_beats;
    int exp_trunc;
  } vec_t;

  beat_t in_q[$];
  beat_t exp_q[$];
  int    frm_len_q[$];
  int    in_frame_left = 0;
  int    exp_frames = 0, exp_truncs = 0;
  int    obs_frames = 0, obs_truncs = 0, obs_beats = 0;
  int    n_cmp = 0, n_err = 0;
  int    valid_pct = 100, ready_pct = 100;
  int    pend_arm = -1, pend_len = -1;
  int    fid = 0;
  bit    last_s_hs = 1'b0;
  bit    prev_stall = 1'b0;
  logic [63:0] prev_pay;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_out();
    return {28'd0, m_if.tdata, m_if.tkeep, m_if.tstrb, m_if.tid, m_if.tdest, m_if.tuser, m_if.tlast};
  endfunction

  function automatic logic [63:0] pack_exp(input beat_t b);
    return {28'd0, b.data, b.keep, b.keep, b.id, 8'd0, b.user, b.last};
  endfunction

  // Reference: when a frame starts, its whole output is decided by len vs. the limit seen then.
  task automatic model_accept();
    if (in_frame_left == 0) begin
      int len  = frm_len_q.pop_front();
      int lim  = int'(max_len);
      int kept = (lim == 0 || len <= lim) ? len : lim;
      for (int i = 0; i < kept; i++) begin
        beat_t b = in_q[i];
        if (i == kept - 1 && kept < len) begin
          b.last = 1'b1;
          b.user[0] = 1'b1;
        end
        exp_q.push_back(b);
      end
      if (kept < len) exp_truncs++;
      exp_frames++;
      in_frame_left = len;
      if (pend_arm >= 0) begin
        pend_len = pend_arm;
        pend_arm = -1;
      end
    end
    void'(in_q.pop_front());
    in_frame_left--;
  endtask

  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = {fid[7:0], i[7:0]};
      b.keep = 2'($urandom_range(1, 3));
      b.id   = 4'($urandom);
      b.user = 3'($urandom) & 3'b110;
      b.last = (i == len - 1);
      in_q.push_back(b);
    end
    frm_len_q.push_back(len);
    fid++;
  endtask

  // One cycle: act at the falling edge, DUT samples at the next rising edge.
  task automatic cyc();
    @(negedge clk);
    if (pend_len >= 0) begin
      max_len = 16'(pend_len);
      pend_len = -1;
    end
    obs_frames += int'(stat_frame);
    obs_truncs += int'(stat_trunc);
    if (prev_stall) begin
      chk("stall_valid", {63'd0, m_if.tvalid}, 64'd1);
      chk("stall_payload", pack_out(), prev_pay);
    end
    m_if.tready = ($urandom_range(99) < ready_pct);
    if (!(s_if.tvalid && !last_s_hs))
      s_if.tvalid = (in_q.size() > 0) && ($urandom_range(99) < valid_pct);
    if (s_if.tvalid) begin
      s_if.tdata = in_q[0].data;
      s_if.tkeep = in_q[0].keep;
      s_if.tid   = in_q[0].id;
      s_if.tuser = in_q[0].user;
      s_if.tlast = in_q[0].last;
    end
    last_s_hs = s_if.tvalid && s_if.tready;
    if (last_s_hs) model_accept();
    if (m_if.tvalid && m_if.tready) begin
      obs_beats++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: actual %0h required none", pack_out());
      end else begin
        chk("beat", pack_out(), pack_exp(exp_q.pop_front()));
      end
    end
    prev_stall = m_if.tvalid && !m_if.tready;
    prev_pay = pack_out();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0 || m_if.tvalid) && n < budget) begin
      cyc();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: actual %0d cycles required < %0d", n, budget);
    end
    repeat (3) cyc();
  endtask

  vec_t tbl[10];

  initial begin
    int b0, f0, t0, c0, n_long;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tstrb = '0;
    s_if.tid = '0; s_if.tdest = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    max_len = '0;

    tbl[0] = '{1,   0, 100,   1, 0};
    tbl[1] = '{5,   0, 100,   5, 0};
    tbl[2] = '{300, 0, 100, 300, 0};
    tbl[3] = '{10,  4, 100,   4, 1};
    tbl[4] = '{4,   4, 100,   4, 0};
    tbl[5] = '{3,   4,  60,   3, 0};
    tbl[6] = '{5,   1, 100,   1, 1};
    tbl[7] = '{1,   1, 100,   1, 0};
    tbl[8] = '{2,   1,  40,   1, 1};
    tbl[9] = '{9,   8,  50,   8, 1};

    // Reset state
    #1;
    chk("rst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
    chk("rst_s_tready", {63'd0, s_if.tready}, 64'd0);
    chk("rst_trunc_count", {32'd0, trunc_count}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    #21 rst_n = 1'b1;
    #1 chk("tready_before_edge", {63'd0, s_if.tready}, 64'd0);

    // First-beat latency
    valid_pct = 100; ready_pct = 100; max_len = 16'd0;
    repeat (2) cyc();
    send_frame(1);
    cyc();
    chk("lat_accept", {63'd0, last_s_hs}, 64'd1);
    @(posedge clk);
    #1;
    chk("lat_valid", {63'd0, m_if.tvalid}, 64'd1);
    chk("lat_data", {48'd0, m_if.tdata}, {48'd0, exp_q[0].data});
    drain(100);

    // Frame vector table
    for (int i = 0; i < 10; i++) begin
      max_len = 16'(tbl[i].lim);
      ready_pct = tbl[i].rdy;
      valid_pct = 100;
      b0 = obs_beats; f0 = obs_frames; t0 = obs_truncs; c0 = int'(trunc_count);
      send_frame(tbl[i].len);
      drain(2000);
      chk($sformatf("v%0d_beats", i), 64'(obs_beats - b0), 64'(tbl[i].exp_beats));
      chk($sformatf("v%0d_frames", i), 64'(obs_frames - f0), 64'd1);
      chk($sformatf("v%0d_trunc_pulse", i), 64'(obs_truncs - t0), 64'(tbl[i].exp_trunc));
      chk($sformatf("v%0d_trunc_count", i), 64'(int'(trunc_count) - c0), 64'(tbl[i].exp_trunc));
    end

    // Limit change after the first beat only affects later frames
    max_len = 16'd3; pend_arm = 100; ready_pct = 100;
    b0 = obs_beats;
    send_frame(6);
    drain(200);
    chk("chg_first_beats", 64'(obs_beats - b0), 64'd3);
    b0 = obs_beats;
    send_frame(6);
    drain(200);
    chk("chg_next_beats", 64'(obs_beats - b0), 64'd6);

    // Random lengths under backpressure
    max_len = 16'd8; ready_pct = 30; valid_pct = 70; n_long = 0;
    f0 = obs_frames; t0 = obs_truncs; c0 = int'(trunc_count);
    for (int k = 0; k < 20; k++) begin
      int len = $urandom_range(1, 16);
      if (len > 8) n_long++;
      send_frame(len);
    end
    drain(5000);
    chk("rand_frames", 64'(obs_frames - f0), 64'd20);
    chk("rand_trunc_pulse", 64'(obs_truncs - t0), 64'(n_long));
    chk("rand_trunc_count", 64'(int'(trunc_count) - c0), 64'(n_long));
    chk("model_trunc_count", {32'd0, trunc_count}, 64'(exp_truncs));
    chk("model_frames", 64'(obs_frames), 64'(exp_frames));

    // Asynchronous reset in the middle of a frame
    max_len = 16'd0; ready_pct = 100; valid_pct = 100;
    send_frame(6);
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
    chk("arst_s_tready", {63'd0, s_if.tready}, 64'd0);
    chk("arst_trunc_count", {32'd0, trunc_count}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_stat", {62'd0, stat_frame, stat_trunc}, 64'd0);
    in_q.delete(); frm_len_q.delete(); exp_q.delete();
    in_frame_left = 0; exp_frames = 0; exp_truncs = 0;
    obs_frames = 0; obs_truncs = 0; obs_beats = 0;
    prev_stall = 1'b0; last_s_hs = 1'b0;
    s_if.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("arst_tready_release", {63'd0, s_if.tready}, 64'd0);
    send_frame(2);
    drain(100);
    chk("arst_post_beats", 64'(obs_beats), 64'd2);
    chk("arst_post_frames", 64'(obs_frames), 64'd1);
    chk("arst_post_trunc", {32'd0, trunc_count}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual timeout required finish");
    $fatal(1, "timeout");
  end
endmodule
